// File: rtl/orv64_boot_image_loader.sv
// Packs a boot byte stream into little-endian words, writes them to memory from BASE_ADDR,
// then releases core reset. Define ORV64_BOOT_ZERO_FILL_EN to zero-fill up to FILL_END_ADDR.
module orv64_boot_image_loader #(
    parameter int unsigned       ADDR_W        = 40,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = 40'h8000_0000,
    parameter logic [ADDR_W-1:0] FILL_END_ADDR = 40'h8103_0000
) (
    input  logic              clk,
    input  logic              dut_rst,
    input  logic              start,
    input  logic              img_valid,
    input  logic [7:0]        img_byte,
    input  logic              img_last,
    output logic              img_ready,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [31:0]       mem_req_wdata,
    input  logic              mem_req_ready,
    output logic              early_rst_out,
    output logic              core_rst_out,
    output logic              start_en_out,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_REL_EARLY,
        S_REL_RST,
        S_REL_START,
        S_DONE,
        S_ERR
`ifdef ORV64_BOOT_ZERO_FILL_EN
        , S_FILL
`endif
    } state_t;

    // One extra bit so addr + 4 can be compared without wrapping.
    localparam logic [ADDR_W:0] WORD_BYTES   = (ADDR_W+1)'(4);
    localparam logic [ADDR_W:0] FILL_END_EXT = {1'b0, FILL_END_ADDR};

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [1:0]        byte_cnt;
    logic              last_seen;
    logic [ADDR_W:0]   addr_sum;
    logic              byte_fire;
    logic              req_fire;

    assign addr_sum  = {1'b0, addr} + WORD_BYTES;
    assign byte_fire = img_ready && img_valid;
    assign req_fire  = mem_req_valid && mem_req_ready;

    // NOTE: every flop is updated with <= so all registers sample the same pre-edge values.
    always_ff @(posedge clk or negedge dut_rst) begin
        if (!dut_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: outputs of this block get a default first, so no path leaves them unassigned (no latch).
    always_comb begin
        state_next    = state;
        img_ready     = 1'b0;
        mem_req_valid = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                img_ready = 1'b1;
                if (img_valid && (byte_cnt == 2'd3 || img_last)) begin
                    // A word that would land at or past the fill bound is never issued.
                    state_next = (addr >= FILL_END_ADDR) ? S_ERR : S_WRITE;
                end
            end
            S_WRITE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    if (!last_seen) begin
                        state_next = S_LOAD;
`ifdef ORV64_BOOT_ZERO_FILL_EN
                    end else if (addr_sum < FILL_END_EXT) begin
                        state_next = S_FILL;
`endif
                    end else begin
                        state_next = S_REL_EARLY;
                    end
                end
            end
`ifdef ORV64_BOOT_ZERO_FILL_EN
            S_FILL: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready && addr_sum >= FILL_END_EXT) state_next = S_REL_EARLY;
            end
`endif
            S_REL_EARLY: state_next = S_REL_RST;
            S_REL_RST:   state_next = S_REL_START;
            S_REL_START: state_next = S_DONE;
            S_DONE:      state_next = S_DONE;
            S_ERR:       state_next = S_ERR;
            default:     state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge dut_rst) begin
        if (!dut_rst) begin
            addr      <= BASE_ADDR;
            wdata     <= '0;
            byte_cnt  <= 2'd0;
            last_seen <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                addr      <= BASE_ADDR;
                wdata     <= '0;
                byte_cnt  <= 2'd0;
                last_seen <= 1'b0;
            end
            if (byte_fire) begin
                for (int k = 0; k < 4; k++) begin
                    if (byte_cnt == 2'(k)) wdata[8*k +: 8] <= img_byte;
                end
                byte_cnt  <= img_last ? 2'd0 : byte_cnt + 2'd1;
                last_seen <= last_seen | img_last;
            end
            // Clearing on each handshake leaves unfilled bytes of a short last word at zero,
            // and makes every fill word zero.
            if (req_fire) begin
                addr  <= addr_sum[ADDR_W-1:0];
                wdata <= '0;
            end
        end
    end

    assign mem_req_addr  = addr;
    assign mem_req_wdata = wdata;

    assign early_rst_out = !(state inside {S_REL_RST, S_REL_START, S_DONE});
    assign core_rst_out  = !(state inside {S_REL_START, S_DONE});
    assign start_en_out  = (state == S_DONE);
    assign busy          = !(state inside {S_IDLE, S_DONE, S_ERR});
    assign done          = (state == S_DONE);
    assign err           = (state == S_ERR);

endmodule

// File: tb/tb_orv64_boot_image_loader.sv
// Directed bench for orv64_boot_image_loader: three instances with different fill bounds
// (default, 8000_0008 for overflow, 8000_0010 for zero fill).
module tb_orv64_boot_image_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        dut_rst;
    logic [2:0]  start_s, img_valid_s, img_last_s, mem_ready_s;
    logic [7:0]  img_byte_s [3];
    logic [2:0]  img_ready_w, mem_valid_w, early_w, core_w, sen_w, busy_w, done_w, err_w;
    logic [39:0] mem_addr_w [3];
    logic [31:0] mem_wdata_w [3];

    int checks = 0;
    int errors = 0;

    logic [7:0]  img [32];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        orv64_boot_image_loader #(
            .ADDR_W        (40),
            .BASE_ADDR     (40'h8000_0000),
            .FILL_END_ADDR (g == 0 ? 40'h8103_0000 : (g == 1 ? 40'h8000_0008 : 40'h8000_0010))
        ) dut (
            .clk           (clk),
            .dut_rst       (dut_rst),
            .start         (start_s[g]),
            .img_valid     (img_valid_s[g]),
            .img_byte      (img_byte_s[g]),
            .img_last      (img_last_s[g]),
            .img_ready     (img_ready_w[g]),
            .mem_req_valid (mem_valid_w[g]),
            .mem_req_addr  (mem_addr_w[g]),
            .mem_req_wdata (mem_wdata_w[g]),
            .mem_req_ready (mem_ready_s[g]),
            .early_rst_out (early_w[g]),
            .core_rst_out  (core_w[g]),
            .start_en_out  (sen_w[g]),
            .busy          (busy_w[g]),
            .done          (done_w[g]),
            .err           (err_w[g])
        );
    end

    // Memory-side log of every accepted write, cleared while reset is held.
    int          wr_n [3];
    logic [39:0] wr_addr [3][16];
    logic [31:0] wr_data [3][16];

    always @(posedge clk) begin
        for (int u = 0; u < 3; u++) begin
            if (!dut_rst) begin
                wr_n[u] <= 0;
            end else if (mem_valid_w[u] && mem_ready_s[u]) begin
                if (wr_n[u] < 16) begin
                    wr_addr[u][wr_n[u][3:0]] <= mem_addr_w[u];
                    wr_data[u][wr_n[u][3:0]] <= mem_wdata_w[u];
                end
                wr_n[u] <= wr_n[u] + 1;
            end
        end
    end

    // All tasks start and end on a falling clock edge.
    task automatic do_reset();
        dut_rst     = 1'b0;
        start_s     = '0;
        img_valid_s = '0;
        img_last_s  = '0;
        mem_ready_s = '1;
        for (int u = 0; u < 3; u++) img_byte_s[u] = 8'h00;
        repeat (2) @(negedge clk);
        dut_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start(input int u);
        start_s[u] = 1'b1;
        @(negedge clk);
        start_s[u] = 1'b0;
    endtask

    task automatic send_byte(input int u, input logic [7:0] b, input logic last);
        int n = 0;
        img_valid_s[u] = 1'b1;
        img_byte_s[u]  = b;
        img_last_s[u]  = last;
        while (!img_ready_w[u] && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL img_accept unit %0d: byte %h not accepted within %0d cycles", u, b, n);
        end
        @(negedge clk);
        img_valid_s[u] = 1'b0;
        img_last_s[u]  = 1'b0;
    endtask

    task automatic send_image(input int u, input int n, input logic with_last);
        for (int i = 0; i < n; i++) send_byte(u, img[i], with_last && (i == n - 1));
    endtask

    task automatic wait_writes(input int u, input int n);
        int k = 0;
        while (wr_n[u] < n && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (wr_n[u] < n) begin
            errors++;
            $display("FAIL wait_writes unit %0d: got %0d writes, expected %0d", u, wr_n[u], n);
        end
    endtask

    task automatic wait_done(input int u);
        int k = 0;
        while (!done_w[u] && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (done_w[u] !== 1'b1) begin
            errors++;
            $display("FAIL wait_done unit %0d: done=%b, expected 1", u, done_w[u]);
        end
    endtask

    // {img_ready, valid, early, core, start_en, busy, done, err}
    function automatic logic [7:0] flags(input int u);
        return {img_ready_w[u], mem_valid_w[u], early_w[u], core_w[u],
                sen_w[u], busy_w[u], done_w[u], err_w[u]};
    endfunction

    task automatic test_reset();
        dut_rst     = 1'b0;
        start_s     = '0;
        img_valid_s = '1;
        img_last_s  = '0;
        mem_ready_s = '1;
        for (int u = 0; u < 3; u++) img_byte_s[u] = 8'h5A;
        repeat (2) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (flags(u) !== 8'b0011_0000) begin
                errors++;
                $display("FAIL reset_flags unit %0d: got %b, expected 00110000", u, flags(u));
            end
            checks++;
            if (mem_addr_w[u] !== 40'h8000_0000) begin
                errors++;
                $display("FAIL reset_addr unit %0d: got %h, expected 8000_0000", u, mem_addr_w[u]);
            end
            checks++;
            if (mem_wdata_w[u] !== 32'h0) begin
                errors++;
                $display("FAIL reset_wdata unit %0d: got %h, expected 0", u, mem_wdata_w[u]);
            end
        end
        dut_rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            checks++;
            if (img_ready_w[u] !== 1'b0 || busy_w[u] !== 1'b0 || mem_wdata_w[u] !== 32'h0) begin
                errors++;
                $display("FAIL idle_no_accept unit %0d: ready=%b busy=%b wdata=%h, expected 0 0 0",
                         u, img_ready_w[u], busy_w[u], mem_wdata_w[u]);
            end
        end
        img_valid_s = '0;
    endtask

    task automatic test_basic();
        logic [3:0] exp_rel [4];
        exp_rel = '{4'b1100, 4'b0100, 4'b0000, 4'b0011};
        do_reset();
        pulse_start(0);
        for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
        send_image(0, 8, 1'b1);
        wait_writes(0, 2);
        // {early, core, start_en, done} across REL_EARLY, REL_RST, REL_START, DONE
        for (int c = 0; c < 4; c++) begin
            checks++;
            if ({early_w[0], core_w[0], sen_w[0], done_w[0]} !== exp_rel[c]) begin
                errors++;
                $display("FAIL release_seq cycle %0d: got %b, expected %b", c,
                         {early_w[0], core_w[0], sen_w[0], done_w[0]}, exp_rel[c]);
            end
            if (c < 3) @(negedge clk);
        end
        checks++;
        if (busy_w[0] !== 1'b0 || err_w[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_flags: busy=%b err=%b, expected 0 0", busy_w[0], err_w[0]);
        end
        checks++;
        if (wr_n[0] !== 2 || wr_addr[0][0] !== 40'h8000_0000 || wr_data[0][0] !== 32'h0403_0201) begin
            errors++;
            $display("FAIL basic_word0: n=%0d addr=%h data=%h, expected 2 8000_0000 04030201",
                     wr_n[0], wr_addr[0][0], wr_data[0][0]);
        end
        checks++;
        if (wr_addr[0][1] !== 40'h8000_0004 || wr_data[0][1] !== 32'h0807_0605) begin
            errors++;
            $display("FAIL basic_word1: addr=%h data=%h, expected 8000_0004 08070605",
                     wr_addr[0][1], wr_data[0][1]);
        end
    endtask

    task automatic test_partial();
        do_reset();
        pulse_start(0);
        img[0] = 8'hAA; img[1] = 8'hBB; img[2] = 8'hCC; img[3] = 8'hDD; img[4] = 8'hEE;
        send_image(0, 5, 1'b1);
        wait_writes(0, 2);
        wait_done(0);
        checks++;
        if (wr_data[0][0] !== 32'hDDCC_BBAA) begin
            errors++;
            $display("FAIL partial_word0: got %h, expected DDCCBBAA", wr_data[0][0]);
        end
        checks++;
        if (wr_addr[0][1] !== 40'h8000_0004 || wr_data[0][1] !== 32'h0000_00EE) begin
            errors++;
            $display("FAIL partial_word1: addr=%h data=%h, expected 8000_0004 000000EE",
                     wr_addr[0][1], wr_data[0][1]);
        end
    endtask

    task automatic test_stall();
        do_reset();
        mem_ready_s[0] = 1'b0;
        pulse_start(0);
        img[0] = 8'h11; img[1] = 8'h22; img[2] = 8'h33; img[3] = 8'h44;
        send_image(0, 4, 1'b1);
        img_valid_s[0] = 1'b1;
        img_byte_s[0]  = 8'h99;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (mem_valid_w[0] !== 1'b1 || mem_addr_w[0] !== 40'h8000_0000 ||
                mem_wdata_w[0] !== 32'h4433_2211 || img_ready_w[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold cycle %0d: valid=%b addr=%h data=%h ready=%b, expected 1 8000_0000 44332211 0",
                         c, mem_valid_w[0], mem_addr_w[0], mem_wdata_w[0], img_ready_w[0]);
            end
            if (c == 7) mem_ready_s[0] = 1'b1;
            @(negedge clk);
        end
        img_valid_s[0] = 1'b0;
        checks++;
        if (wr_n[0] !== 1 || wr_data[0][0] !== 32'h4433_2211) begin
            errors++;
            $display("FAIL stall_write: n=%0d data=%h, expected 1 44332211", wr_n[0], wr_data[0][0]);
        end
        wait_done(0);
    endtask

    task automatic test_fill();
        int exp_n;
`ifdef ORV64_BOOT_ZERO_FILL_EN
        exp_n = 4;
`else
        exp_n = 1;
`endif
        do_reset();
        pulse_start(2);
        img[0] = 8'hDE; img[1] = 8'hAD; img[2] = 8'hBE; img[3] = 8'hEF;
        send_image(2, 4, 1'b1);
        wait_done(2);
        repeat (3) @(negedge clk);
        checks++;
        if (wr_n[2] !== exp_n || err_w[2] !== 1'b0) begin
            errors++;
            $display("FAIL fill_count: n=%0d err=%b, expected %0d 0", wr_n[2], err_w[2], exp_n);
        end
        checks++;
        if (wr_addr[2][0] !== 40'h8000_0000 || wr_data[2][0] !== 32'hEFBE_ADDE) begin
            errors++;
            $display("FAIL fill_image_word: addr=%h data=%h, expected 8000_0000 EFBEADDE",
                     wr_addr[2][0], wr_data[2][0]);
        end
        for (int i = 1; i < exp_n; i++) begin
            checks++;
            if (wr_addr[2][i] !== 40'h8000_0000 + 40'(4 * i) || wr_data[2][i] !== 32'h0) begin
                errors++;
                $display("FAIL fill_zero_word %0d: addr=%h data=%h, expected %h 0", i,
                         wr_addr[2][i], wr_data[2][i], 40'h8000_0000 + 40'(4 * i));
            end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        pulse_start(1);
        for (int i = 0; i < 12; i++) img[i] = 8'(i + 1);
        send_image(1, 12, 1'b1);
        repeat (3) @(negedge clk);
        // {img_ready, valid, early, core, start_en, busy, done, err}
        checks++;
        if (flags(1) !== 8'b0011_0001) begin
            errors++;
            $display("FAIL overflow_flags: got %b, expected 00110001", flags(1));
        end
        checks++;
        if (wr_n[1] !== 2 || wr_addr[1][1] !== 40'h8000_0004 || wr_data[1][1] !== 32'h0807_0605) begin
            errors++;
            $display("FAIL overflow_writes: n=%0d addr=%h data=%h, expected 2 8000_0004 08070605",
                     wr_n[1], wr_addr[1][1], wr_data[1][1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse_start(0);
        for (int i = 0; i < 6; i++) img[i] = 8'(i + 1);
        send_image(0, 6, 1'b0);
        checks++;
        if (wr_n[0] !== 1 || busy_w[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_before_reset: n=%0d busy=%b, expected 1 1", wr_n[0], busy_w[0]);
        end
        dut_rst = 1'b0;
        #1;
        checks++;
        if (flags(0) !== 8'b0011_0000 || mem_addr_w[0] !== 40'h8000_0000 || mem_wdata_w[0] !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_values: flags=%b addr=%h data=%h, expected 00110000 8000_0000 0",
                     flags(0), mem_addr_w[0], mem_wdata_w[0]);
        end
        repeat (2) @(negedge clk);
        dut_rst = 1'b1;
        @(negedge clk);
        pulse_start(0);
        img[0] = 8'h55; img[1] = 8'h66; img[2] = 8'h77; img[3] = 8'h88;
        send_image(0, 4, 1'b1);
        wait_writes(0, 1);
        checks++;
        if (wr_addr[0][0] !== 40'h8000_0000 || wr_data[0][0] !== 32'h8877_6655) begin
            errors++;
            $display("FAIL mid_reload: addr=%h data=%h, expected 8000_0000 88776655",
                     wr_addr[0][0], wr_data[0][0]);
        end
        wait_done(0);
    endtask

    task automatic test_start_ignored();
        pulse_start(0);
        img_valid_s[0] = 1'b1;
        img_byte_s[0]  = 8'h77;
        repeat (5) @(negedge clk);
        checks++;
        if (flags(0) !== 8'b0000_1010 || wr_n[0] !== 1) begin
            errors++;
            $display("FAIL start_in_done: flags=%b n=%0d, expected 00001010 1", flags(0), wr_n[0]);
        end
        img_valid_s[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_stall();
        test_fill();
        test_overflow();
        test_reset_mid();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
